count_sum_bcd: RTL

Parametrised AXI-Stream frame accumulator with a decimal seven-segment display output. It sums up to `N` accepted input beats, closing early on `s_last`. It then converts the binary total to `DIGITS` BCD digits with a serial double-dabble engine and presents one seven-segment code per digit on a held output beat. It sits between a sample source and the display driver, and generalises the fixed two-digit `count_sum` to arbitrary width, frame depth and digit count, with early frame close, overflow saturation and leading-zero blanking.

---
 rtl/count_sum_pkg.sv | 42 ++++
 rtl/bin2bcd_serial.sv | 81 ++++++++
 rtl/count_sum_bcd.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/count_sum_pkg.sv
// count_sum_pkg
// Shared definitions for the count_sum_bcd frame accumulator:
//   state_t : FSM states of the top level (accumulate, convert, present)
//   seg7()  : BCD digit to seven-segment code, bit order {g,f,e,d,c,b,a},
//             active-high; non-decimal nibbles map to all segments off
//   pow10() : 10^n, used to build the overflow threshold at elaboration
package count_sum_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CONV  = 2'd1,
        OUT   = 2'd2
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b0111111;
            4'd1:    code = 7'b0000110;
            4'd2:    code = 7'b1011011;
            4'd3:    code = 7'b1001111;
            4'd4:    code = 7'b1100110;
            4'd5:    code = 7'b1101101;
            4'd6:    code = 7'b1111101;
            4'd7:    code = 7'b0000111;
            4'd8:    code = 7'b1111111;
            4'd9:    code = 7'b1101111;
            default: code = 7'b0000000;
        endcase
        return code;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial
// Serial double-dabble converter: one bit of the binary input per clock.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   start     : load bin and begin a conversion (ignored priority-wise
//               by nothing; the caller only pulses it while idle)
//   bin[SW]   : binary value to convert, sampled when start is high
//   busy      : conversion in progress
//   done      : one-cycle pulse, bcd is valid from this cycle on
//   bcd       : DIGITS packed BCD nibbles, index 0 is the ones digit
// A conversion takes exactly SW cycles after the start edge. Only the low
// DIGITS nibbles are kept; any carry beyond them is dropped, which only
// matters for values the caller already treats as overflow.
module bin2bcd_serial #(
    parameter int SW     = 6,
    parameter int DIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [SW-1:0]          bin,
    output logic                   busy,
    output logic                   done,
    output logic [DIGITS-1:0][3:0] bcd
);

    localparam int STW = $clog2(SW + 1);

    logic [SW-1:0]          shift_q, shift_d;
    logic [DIGITS-1:0][3:0] bcd_q, bcd_d, bcd_adj;
    logic [STW-1:0]         step_q, step_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Add-3 correction on every nibble that would reach 10+ after the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi] = (bcd_q[gi] >= 4'd5) ? (bcd_q[gi] + 4'd3) : bcd_q[gi];
    end

    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start) begin
            shift_d = bin;
            bcd_d   = '0;
            step_d  = STW'(SW);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            step_d           = step_q - STW'(1);
            if (step_q == STW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/count_sum_bcd.sv
// count_sum_bcd
// AXI-Stream frame accumulator with a decimal seven-segment result beat.
// Sums up to N accepted beats (closing early on s_last), converts the total
// to DIGITS BCD digits and holds one seg7 code per digit until accepted.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   s_valid/s_ready  : input handshake (s_ready registered)
//   s_data[W]        : unsigned sample
//   s_last           : closes the frame after this beat
//   m_valid/m_ready  : output handshake (m_valid registered)
//   m_data           : [DIGITS-1:0][6:0] segment codes, index 0 = ones digit
//   m_ovf            : total exceeded 10^DIGITS-1 (all digits show 9)
//   m_count          : number of beats in the frame
module count_sum_bcd
    import count_sum_pkg::*;
#(
    parameter int W        = 3,
    parameter int N        = 5,
    parameter int DIGITS   = 2,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [W-1:0]                 s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DIGITS-1:0][6:0]       m_data,
    output logic                         m_ovf,
    output logic [$clog2(N+1)-1:0]       m_count
);

    // Accumulator is wide enough for N full-scale samples, so it never wraps.
    localparam int SW = $clog2(N * (2**W - 1) + 1);
    localparam int CW = $clog2(N + 1);
    localparam longint unsigned OVF_LIMIT = pow10(DIGITS);

    state_t                 state_q, state_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   s_ready_q, s_ready_d;
    logic                   m_valid_q, m_valid_d;
    logic [DIGITS-1:0][6:0] m_data_q, m_data_d;
    logic                   m_ovf_q, m_ovf_d;
    logic [CW-1:0]          m_count_q, m_count_d;

    logic                   conv_start;
    logic                   conv_busy;
    logic                   conv_done;
    logic [DIGITS-1:0][3:0] conv_bcd;
    logic                   ovf_now;
    logic [DIGITS-1:0][6:0] seg_vec;

    // The converter is loaded with sum_d so the closing beat is included.
    bin2bcd_serial #(
        .SW     (SW),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (conv_start),
        .bin   (sum_d),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // sum_q still holds the frame total while converting.
    assign ovf_now = (64'(sum_q) >= OVF_LIMIT);

    // Digit 0 is never blanked; an upper digit is blank only when it and
    // every digit above it are zero. Overflow forces 9 everywhere.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
        if (gi == 0) begin : g_ones
            assign seg_vec[gi] = ovf_now ? seg7(4'd9) : seg7(conv_bcd[gi]);
        end else begin : g_upper
            logic upper_nz;
            assign upper_nz    = |conv_bcd[DIGITS-1:gi];
            assign seg_vec[gi] = ovf_now ? seg7(4'd9) :
                                 (BLANK_LZ && !upper_nz) ? 7'b0000000 :
                                 seg7(conv_bcd[gi]);
        end
    end

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        s_ready_d  = s_ready_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_ovf_d    = m_ovf_q;
        m_count_d  = m_count_q;
        conv_start = 1'b0;
        case (state_q)
            ACCUM: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    sum_d = sum_q + SW'(s_data);
                    cnt_d = cnt_q + CW'(1);
                    if ((cnt_d == CW'(N)) || s_last) begin
                        state_d    = CONV;
                        conv_start = 1'b1;
                        s_ready_d  = 1'b0;
                    end
                end
            end
            CONV: begin
                s_ready_d = 1'b0;
                if (conv_done && !conv_busy) begin
                    state_d   = OUT;
                    m_valid_d = 1'b1;
                    m_data_d  = seg_vec;
                    m_ovf_d   = ovf_now;
                    m_count_d = cnt_q;
                end
            end
            OUT: begin
                if (m_valid_q && m_ready) begin
                    state_d   = ACCUM;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    sum_d     = '0;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ACCUM;
            sum_q     <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ovf_q   <= 1'b0;
            m_count_q <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ovf_q   <= m_ovf_d;
            m_count_q <= m_count_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ovf   = m_ovf_q;
    assign m_count = m_count_q;

endmodule
